// File: rtl/fft16_stage1_ctrl.sv
// Stage-1 sequencer for a 16-point radix-4 FFT: it turns a serial input into a parallel butterfly frame
// and streams the captured results back out. Optional macro FFT16_S1_OVERLAP_EN loads the next frame while results drain.
module fft16_stage1_ctrl #(
  parameter int unsigned BFLY_LAT = 1  // legal range 1..15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [15:0]  in_re,
  input  logic [15:0]  in_im,
  output logic [255:0] bfly_re_o,
  output logic [255:0] bfly_im_o,
  input  logic [255:0] bfly_re_i,
  input  logic [255:0] bfly_im_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [15:0]  out_re,
  output logic [15:0]  out_im,
  output logic         out_last,
  output logic         busy,
  output logic [1:0]   dbg_state_o
);

  // Handshakes: a beat transfers on a rising edge where valid && ready. in_ready and out_valid
  // come only from registered state; they never look at in_valid or out_ready.
  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_HOLD    = 2'd2
  } state_e;

  localparam logic [3:0] LAT_M1 = 4'(BFLY_LAT - 1);

  state_e       state_q, state_d;
  logic [3:0]   wr_idx_q, wr_idx_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   rd_idx_q, rd_idx_d;
  logic         res_full_q, res_full_d;
  logic [255:0] in_re_q, in_im_q;
  logic [255:0] res_re_q, res_im_q;

  logic in_hs;
  logic out_hs;
  logic last_hs;
  logic cnt_done;
  logic capture;

  // State register and data buffers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LOAD;
      wr_idx_q   <= '0;
      cnt_q      <= '0;
      rd_idx_q   <= '0;
      res_full_q <= 1'b0;
      in_re_q    <= '0;
      in_im_q    <= '0;
      res_re_q   <= '0;
      res_im_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      cnt_q      <= cnt_d;
      rd_idx_q   <= rd_idx_d;
      res_full_q <= res_full_d;
      if (in_hs) begin
        in_re_q[{wr_idx_q, 4'b0000} +: 16] <= in_re;
        in_im_q[{wr_idx_q, 4'b0000} +: 16] <= in_im;
      end
      if (capture) begin
        res_re_q <= bfly_re_i;
        res_im_q <= bfly_im_i;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    cnt_d      = '0;
    rd_idx_d   = rd_idx_q;
    res_full_d = res_full_q;

    unique case (state_q)
      S_LOAD: begin
        if (in_hs) begin
          wr_idx_d = wr_idx_q + 4'd1;
          if (wr_idx_q == 4'd15) state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        cnt_d = cnt_q + 4'd1;
        // The last compute cycle captures directly when the result buffer is free.
        if (cnt_done) state_d = capture ? S_LOAD : S_HOLD;
      end
      S_HOLD: begin
        if (capture) state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase

    if (capture) begin
      res_full_d = 1'b1;
      rd_idx_d   = '0;
    end else if (out_hs) begin
      rd_idx_d = rd_idx_q + 4'd1;
      if (last_hs) res_full_d = 1'b0;
    end
  end

  // Outputs and handshake decode
  always_comb begin
`ifdef FFT16_S1_OVERLAP_EN
    in_ready = (state_q == S_LOAD);
`else
    in_ready = (state_q == S_LOAD) && !res_full_q;
`endif
    out_valid   = res_full_q;
    out_re      = res_full_q ? res_re_q[{rd_idx_q, 4'b0000} +: 16] : 16'h0000;
    out_im      = res_full_q ? res_im_q[{rd_idx_q, 4'b0000} +: 16] : 16'h0000;
    out_last    = res_full_q && (rd_idx_q == 4'd15);
    busy        = (state_q != S_LOAD) || (wr_idx_q != 4'd0) || res_full_q;
    dbg_state_o = state_q;
    bfly_re_o   = in_re_q;
    bfly_im_o   = in_im_q;

    in_hs    = in_valid && in_ready;
    out_hs   = res_full_q && out_ready;
    last_hs  = out_hs && (rd_idx_q == 4'd15);
    cnt_done = (state_q == S_COMPUTE) && (cnt_q == LAT_M1);
    // A final drain beat frees the buffer in the same edge the new frame lands.
    capture  = (cnt_done || (state_q == S_HOLD)) && (!res_full_q || last_hs);
  end

endmodule

// File: tb/tb_fft16_stage1_ctrl.sv
// Bench for fft16_stage1_ctrl: two instances (BFLY_LAT=1 and 4) with a bench-side butterfly model and
// an expected-result queue; build with FFT16_S1_OVERLAP_EN to exercise the overlapped variant.
module tb_fft16_stage1_ctrl;

`ifdef FFT16_S1_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared stimulus; sel picks which instance is active
  logic        sel;
  logic        in_valid, out_ready;
  logic [15:0] in_re, in_im;

  logic         in_ready_a, out_valid_a, out_last_a, busy_a;
  logic [15:0]  out_re_a, out_im_a;
  logic [1:0]   st_a;
  logic [255:0] bfly_re_o_a, bfly_im_o_a, bfly_re_i_a, bfly_im_i_a;
  logic         in_ready_b, out_valid_b, out_last_b, busy_b;
  logic [15:0]  out_re_b, out_im_b;
  logic [1:0]   st_b;
  logic [255:0] bfly_re_o_b, bfly_im_o_b, bfly_re_i_b, bfly_im_i_b;
  logic [255:0] p_re [3];
  logic [255:0] p_im [3];

  logic         in_ready_s, out_valid_s, out_last_s, busy_s;
  logic [15:0]  out_re_s, out_im_s;
  logic [1:0]   st_s;
  logic [255:0] bfly_re_s, bfly_im_s;

  fft16_stage1_ctrl #(.BFLY_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && !sel), .in_ready(in_ready_a),
    .in_re(in_re), .in_im(in_im), .bfly_re_o(bfly_re_o_a), .bfly_im_o(bfly_im_o_a),
    .bfly_re_i(bfly_re_i_a), .bfly_im_i(bfly_im_i_a), .out_valid(out_valid_a),
    .out_ready(out_ready && !sel), .out_re(out_re_a), .out_im(out_im_a),
    .out_last(out_last_a), .busy(busy_a), .dbg_state_o(st_a)
  );

  fft16_stage1_ctrl #(.BFLY_LAT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel), .in_ready(in_ready_b),
    .in_re(in_re), .in_im(in_im), .bfly_re_o(bfly_re_o_b), .bfly_im_o(bfly_im_o_b),
    .bfly_re_i(bfly_re_i_b), .bfly_im_i(bfly_im_i_b), .out_valid(out_valid_b),
    .out_ready(out_ready && sel), .out_re(out_re_b), .out_im(out_im_b),
    .out_last(out_last_b), .busy(busy_b), .dbg_state_o(st_b)
  );

  // Butterfly model: result k re = x[k].re + x[k+1].im, im = x[k].im - x[15-k].re
  function automatic logic [255:0] bf_re(input logic [255:0] re, input logic [255:0] im);
    logic [255:0] r;
    for (int k = 0; k < 16; k++) r[16*k +: 16] = re[16*k +: 16] + im[16*((k+1)%16) +: 16];
    return r;
  endfunction
  function automatic logic [255:0] bf_im(input logic [255:0] re, input logic [255:0] im);
    logic [255:0] r;
    for (int k = 0; k < 16; k++) r[16*k +: 16] = im[16*k +: 16] - re[16*(15-k) +: 16];
    return r;
  endfunction

  assign bfly_re_i_a = bf_re(bfly_re_o_a, bfly_im_o_a);
  assign bfly_im_i_a = bf_im(bfly_re_o_a, bfly_im_o_a);
  always @(posedge clk) begin
    p_re[0] <= bf_re(bfly_re_o_b, bfly_im_o_b);
    p_im[0] <= bf_im(bfly_re_o_b, bfly_im_o_b);
    p_re[1] <= p_re[0];
    p_im[1] <= p_im[0];
    p_re[2] <= p_re[1];
    p_im[2] <= p_im[1];
  end
  assign bfly_re_i_b = p_re[2];
  assign bfly_im_i_b = p_im[2];

  always_comb begin
    in_ready_s  = sel ? in_ready_b  : in_ready_a;
    out_valid_s = sel ? out_valid_b : out_valid_a;
    out_last_s  = sel ? out_last_b  : out_last_a;
    busy_s      = sel ? busy_b      : busy_a;
    out_re_s    = sel ? out_re_b    : out_re_a;
    out_im_s    = sel ? out_im_b    : out_im_a;
    st_s        = sel ? st_b        : st_a;
    bfly_re_s   = sel ? bfly_re_o_b : bfly_re_o_a;
    bfly_im_s   = sel ? bfly_im_o_b : bfly_im_o_a;
  end

  // Scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];
  logic [15:0] sre [16];
  logic [15:0] sim [16];
  int unsigned hs_cyc;
  int ird_bad = 0;
  int gap_bad = 0;
  int coin_cnt = 0;
  logic coin_pend = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid_s && out_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected_out", 1, 0);
      else check("out_data", {out_last_s, out_re_s, out_im_s}, exp_q.pop_front());
    end
  end

  // in_ready is high only in LOAD, and in the plain build only while no result is pending
  always @(negedge clk) begin
    if (rst_n && (in_ready_s !== ((st_s == 2'd0) && (OVL || !out_valid_s)))) ird_bad++;
    if (rst_n && !sel) begin
      if (coin_pend && !out_valid_s) gap_bad++;
      coin_pend = (st_s == 2'd2) && out_valid_s && out_ready && out_last_s;
      if (coin_pend) coin_cnt++;
    end
  end

  // Driver tasks
  task automatic rand_frame();
    for (int k = 0; k < 16; k++) begin
      sre[k] = 16'($urandom_range(0, 65535));
      sim[k] = 16'($urandom_range(0, 65535));
    end
  endtask

  task automatic push_frame();
    for (int k = 0; k < 16; k++)
      exp_q.push_back({(k == 15), 16'(sre[k] + sim[(k+1)%16]), 16'(sim[k] - sre[15-k])});
  endtask

  task automatic send_sample(input logic [15:0] re, input logic [15:0] im);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_re = re;
    in_im = im;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready_s) begin
        hs_cyc = cyc;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int n);
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) send_sample(sre[i], sim[i]);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int unsigned c);
    c = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (out_valid_s) begin
        c = cyc;
        return;
      end
    end
    check("out_valid_timeout", 0, 1);
  endtask

  task automatic wait_drain(input string tag);
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid_s) break;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_idle"}, busy_s, 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, in_ready_s, 1);
    check({tag, "_out_valid"}, out_valid_s, 0);
    check({tag, "_out_re"}, out_re_s, 0);
    check({tag, "_out_im"}, out_im_s, 0);
    check({tag, "_out_last"}, out_last_s, 0);
    check({tag, "_busy"}, busy_s, 0);
    check({tag, "_bfly_re"}, bfly_re_s, 0);
    check({tag, "_bfly_im"}, bfly_im_s, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c;
    int bad;
    logic [255:0] pk_re, pk_im;
    bit done;

    rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_re = '0; in_im = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst_a");
    sel = 1'b1;
    #1;
    check_reset("rst_b");
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Ramp frame at full rate, LAT=1
    for (int k = 0; k < 16; k++) begin
      sre[k] = 16'(k);
      sim[k] = 16'(-k);
    end
    push_frame();
    send_frame(16);
    wait_valid(c);
    check("lat1_first_valid", c - hs_cyc, 2);
    check("in_ready_at_capture", in_ready_s, OVL);
    wait_drain("ramp");

    // Downstream stall for 10 cycles after out_valid rises
    out_ready = 1'b0;
    rand_frame();
    push_frame();
    send_frame(16);
    wait_valid(c);
    bad = 0;
    for (int t = 0; t < 10; t++) begin
      if ({out_valid_s, out_last_s, out_re_s, out_im_s} !== {1'b1, exp_q[0]}) bad++;
      @(negedge clk);
    end
    check("stall_hold_idx0", bad, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (!out_valid_s) break;
    end
    check("in_ready_after_drain", in_ready_s, 1);
    wait_drain("stall");

    // Back-to-back frames with random downstream stalls
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < 3; f++) begin
          rand_frame();
          push_frame();
          send_frame(16);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain("b2b");

`ifdef FFT16_S1_OVERLAP_EN
    // Second frame's capture lands on the first frame's last drain beat
    out_ready = 1'b0;
    fork
      begin
        rand_frame();
        push_frame();
        send_frame(16);
        rand_frame();
        push_frame();
        send_frame(16);
      end
      begin
        wait_valid(c);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain("ovl");
    check("coincide_seen", (coin_cnt > 0), 1);
    check("coincide_no_gap", gap_bad, 0);
`endif

    // Reset after 7 samples, then a clean frame
    rand_frame();
    send_frame(7);
    check("busy_partial", busy_s, 1);
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    rand_frame();
    push_frame();
    send_frame(16);
    wait_drain("post_rst");

    // LAT=4: frozen butterfly inputs through COMPUTE and latency
    sel = 1'b1;
    rand_frame();
    for (int k = 0; k < 16; k++) begin
      pk_re[16*k +: 16] = sre[k];
      pk_im[16*k +: 16] = sim[k];
    end
    push_frame();
    send_frame(16);
    bad = 0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if (bfly_re_s !== pk_re || bfly_im_s !== pk_im || st_s !== 2'd1) bad++;
    end
    check("lat4_frozen_compute", bad, 0);
    wait_valid(c);
    check("lat4_first_valid", c - hs_cyc, 5);
    wait_drain("lat4");
    sel = 1'b0;

    check("in_ready_rule", ird_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
